// File: rtl/multiway_light_controller.sv
// Multi-approach traffic light controller: one green approach at a time,
// round-robin hand-over on demand, yellow and all-red clearance, and a night
// flashing mode. Lights decode from registered state; phase_start is registered.
module multiway_light_controller #(
   parameter int NUM_DIR     = 4,
   parameter int DIR_BIT     = 2,
   parameter int TIMER_BIT   = 4,
   parameter int GREEN_MIN   = 4,
   parameter int GREEN_MAX   = 8,
   parameter int YELLOW_TIME = 2,
   parameter int ALLRED_TIME = 1,
   parameter int FLASH_HALF  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_DIR-1:0]     car,
   input  logic                   flash,
   output logic [3*NUM_DIR-1:0]   lights,
   output logic [DIR_BIT-1:0]     cur_dir,
   output logic                   phase_start
);

   typedef enum logic [1:0] {
      ST_GREEN  = 2'd0,
      ST_YELLOW = 2'd1,
      ST_ALLRED = 2'd2,
      ST_FLASH  = 2'd3
   } state_t;

   localparam logic [2:0] LT_GREEN  = 3'b001;
   localparam logic [2:0] LT_YELLOW = 3'b010;
   localparam logic [2:0] LT_RED    = 3'b100;
   localparam logic [2:0] LT_DARK   = 3'b000;

   // Terminal counts for each timed phase, sized to the phase counter.
   localparam logic [TIMER_BIT-1:0] G_MIN_M1 = TIMER_BIT'(GREEN_MIN - 1);
   localparam logic [TIMER_BIT-1:0] G_MAX_M1 = TIMER_BIT'(GREEN_MAX - 1);
   localparam logic [TIMER_BIT-1:0] Y_M1     = TIMER_BIT'(YELLOW_TIME - 1);
   localparam logic [TIMER_BIT-1:0] A_M1     = TIMER_BIT'(ALLRED_TIME - 1);
   localparam logic [TIMER_BIT-1:0] F_M1     = TIMER_BIT'(FLASH_HALF - 1);

   state_t                 state;
   logic [TIMER_BIT-1:0]   cnt;
   logic [DIR_BIT-1:0]     next_dir;
   logic                   pend_flash;
   logic                   flash_on;

   logic [NUM_DIR-1:0]     cur_mask;
   logic                   other_req;
   logic                   cur_car;
   logic                   green_done;

   // First requesting approach after 'from', wrapping past NUM_DIR-1 to 0.
   // Falls back to 'from' when nobody else is asking.
   function automatic logic [DIR_BIT-1:0] rr_pick(input logic [NUM_DIR-1:0] req,
                                                  input logic [DIR_BIT-1:0] from);
      logic [DIR_BIT-1:0] pick;
      logic [NUM_DIR-1:0] sh;
      logic               found;
      int                 t;
      pick  = from;
      found = 1'b0;
      for (int k = 1; k < NUM_DIR; k++) begin
         t = int'(from) + k;
         if (t >= NUM_DIR) t = t - NUM_DIR;
         sh = req >> t;
         if (!found && sh[0]) begin
            found = 1'b1;
            pick  = DIR_BIT'(t);
         end
      end
      return pick;
   endfunction

   assign cur_mask  = NUM_DIR'(1) << cur_dir;
   assign other_req = |(car & ~cur_mask);
   assign cur_car   = |(car & cur_mask);

   // Green may hand over once it has hit the maximum, or reached the minimum
   // with its own approach empty; either way only if someone else is waiting.
   assign green_done = other_req &&
                       ((cnt == G_MAX_M1) || ((cnt >= G_MIN_M1) && !cur_car));

   // Phase sequencer: state, phase counter, grant registers and phase_start pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_GREEN;
         cnt         <= '0;
         cur_dir     <= '0;
         next_dir    <= '0;
         pend_flash  <= 1'b0;
         flash_on    <= 1'b0;
         phase_start <= 1'b0;
      end else begin
         phase_start <= 1'b0;
         case (state)
            ST_GREEN: begin
               // Flash wins over car hand-over once minimum green is served.
               if (flash && (cnt >= G_MIN_M1)) begin
                  state      <= ST_YELLOW;
                  cnt        <= '0;
                  pend_flash <= 1'b1;
               end else if (green_done) begin
                  state    <= ST_YELLOW;
                  cnt      <= '0;
                  next_dir <= rr_pick(car, cur_dir);
               end else if (cnt != G_MAX_M1) begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_YELLOW: begin
               if (cnt == Y_M1) begin
                  state <= ST_ALLRED;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_ALLRED: begin
               if (cnt == A_M1) begin
                  cnt <= '0;
                  if (pend_flash) begin
                     state    <= ST_FLASH;
                     flash_on <= 1'b1;
                  end else begin
                     state       <= ST_GREEN;
                     cur_dir     <= next_dir;
                     phase_start <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               // Leaving flash: clear to all-red, then restart at approach 0.
               if (!flash) begin
                  state      <= ST_ALLRED;
                  cnt        <= '0;
                  pend_flash <= 1'b0;
                  next_dir   <= '0;
               end else if (cnt == F_M1) begin
                  cnt      <= '0;
                  flash_on <= ~flash_on;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         endcase
      end
   end

   // Per-approach lamp decode from the registered state.
   always_comb begin
      lights = '0;
      for (int i = 0; i < NUM_DIR; i++) begin
         case (state)
            ST_GREEN:  lights[3*i +: 3] = (cur_dir == DIR_BIT'(i)) ? LT_GREEN  : LT_RED;
            ST_YELLOW: lights[3*i +: 3] = (cur_dir == DIR_BIT'(i)) ? LT_YELLOW : LT_RED;
            ST_ALLRED: lights[3*i +: 3] = LT_RED;
            default:   lights[3*i +: 3] = flash_on ? LT_YELLOW : LT_DARK;
         endcase
      end
   end

endmodule

// File: tb/tb_multiway_light_controller.sv
// Scoreboard bench for multiway_light_controller at default parameters.
// Expected per-cycle lights/cur_dir/phase_start are queued from hand-written
// phase tables and compared one entry per clock, sampled 1 time unit after the edge.
module tb_multiway_light_controller;

   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] D = 3'b000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  car = '0;
   logic        flash = 1'b0;
   logic [11:0] lights;
   logic [1:0]  cur_dir;
   logic        phase_start;

   typedef struct {
      logic [11:0] l;
      logic [1:0]  d;
      logic        p;
   } exp_t;

   exp_t  exp_q[$];
   int    n_checks = 0;
   int    n_err    = 0;
   string scen     = "init";

   multiway_light_controller #(
      .NUM_DIR(4), .DIR_BIT(2), .TIMER_BIT(4),
      .GREEN_MIN(4), .GREEN_MAX(8), .YELLOW_TIME(2), .ALLRED_TIME(1), .FLASH_HALF(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .car(car),
      .flash(flash),
      .lights(lights),
      .cur_dir(cur_dir),
      .phase_start(phase_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s/%s: got %0h expected %0h", scen, tag, act, exp);
      end
   endtask

   // Pattern 'pat' on approach 'dir', red on every other approach.
   function automatic logic [11:0] lt(input int dir, input logic [2:0] pat);
      logic [11:0] v;
      for (int i = 0; i < 4; i++) v[3*i +: 3] = (i == dir) ? pat : R;
      return v;
   endfunction

   function automatic logic [11:0] all_of(input logic [2:0] pat);
      return {pat, pat, pat, pat};
   endfunction

   task automatic push(input int n, input logic [11:0] l, input logic [1:0] d, input logic p);
      exp_t e;
      e.l = l; e.d = d; e.p = p;
      for (int i = 0; i < n; i++) exp_q.push_back(e);
   endtask

   // Compare n queued entries against n consecutive cycles, advancing after each.
   task automatic run_check(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         if (exp_q.size() == 0) begin
            check("sb_underrun", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("lights",      32'(lights),      32'(e.l));
            check("cur_dir",     32'(cur_dir),     32'(e.d));
            check("phase_start", 32'(phase_start), 32'(e.p));
         end
         @(posedge clk); #1;
      end
   endtask

   // Hold reset for two edges, check the forced state, release at edge+1.
   task automatic do_reset();
      rst   = 1'b1;
      car   = '0;
      flash = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_lights", 32'(lights),      32'(lt(0, G)));
      check("rst_dir",    32'(cur_dir),     32'd0);
      check("rst_ps",     32'(phase_start), 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      // Idle after reset: rest in green on approach 0, no pulses.
      scen = "idle";
      do_reset();
      push(50, lt(0, G), 2'd0, 1'b0);
      run_check(50);

      // Single request on approach 2: minimum green, clearance, hand-over.
      scen = "req2";
      do_reset();
      car = 4'b0100;
      push(4, lt(0, G), 2'd0, 1'b0);
      push(2, lt(0, Y), 2'd0, 1'b0);
      push(1, all_of(R), 2'd0, 1'b0);
      push(1, lt(2, G), 2'd2, 1'b1);
      push(2, lt(2, G), 2'd2, 1'b0);
      run_check(10);

      // Both 0 and 1 waiting: green extends to the maximum, then goes to 1.
      scen = "extend";
      do_reset();
      car = 4'b0011;
      push(8, lt(0, G), 2'd0, 1'b0);
      push(2, lt(0, Y), 2'd0, 1'b0);
      push(1, all_of(R), 2'd0, 1'b0);
      push(1, lt(1, G), 2'd1, 1'b1);
      push(3, lt(1, G), 2'd1, 1'b0);
      run_check(15);

      // Wrap-around: from approach 3 with 1 and 2 waiting, approach 1 wins.
      scen = "wrap";
      do_reset();
      car = 4'b1000;
      push(4, lt(0, G), 2'd0, 1'b0);
      push(2, lt(0, Y), 2'd0, 1'b0);
      push(1, all_of(R), 2'd0, 1'b0);
      push(1, lt(3, G), 2'd3, 1'b1);
      run_check(8);
      car = 4'b0110;
      push(3, lt(3, G), 2'd3, 1'b0);
      push(2, lt(3, Y), 2'd3, 1'b0);
      push(1, all_of(R), 2'd3, 1'b0);
      push(1, lt(1, G), 2'd1, 1'b1);
      run_check(7);

      // Flash from green cycle 1 (with a car also waiting), then back to normal.
      scen = "flash";
      do_reset();
      car = 4'b0010;
      push(1, lt(0, G), 2'd0, 1'b0);
      run_check(1);
      flash = 1'b1;
      push(3, lt(0, G), 2'd0, 1'b0);
      push(2, lt(0, Y), 2'd0, 1'b0);
      push(1, all_of(R), 2'd0, 1'b0);
      push(2, all_of(Y), 2'd0, 1'b0);
      push(2, all_of(D), 2'd0, 1'b0);
      push(2, all_of(Y), 2'd0, 1'b0);
      run_check(12);
      flash = 1'b0;
      push(1, all_of(D), 2'd0, 1'b0);
      push(1, all_of(R), 2'd0, 1'b0);
      push(1, lt(0, G), 2'd0, 1'b1);
      push(2, lt(0, G), 2'd0, 1'b0);
      run_check(5);

      // Reset asserted mid-yellow on approach 2 takes effect immediately.
      scen = "rst_yel";
      do_reset();
      car = 4'b0100;
      push(4, lt(0, G), 2'd0, 1'b0);
      push(2, lt(0, Y), 2'd0, 1'b0);
      push(1, all_of(R), 2'd0, 1'b0);
      push(1, lt(2, G), 2'd2, 1'b1);
      run_check(8);
      car = 4'b0001;
      push(3, lt(2, G), 2'd2, 1'b0);
      push(1, lt(2, Y), 2'd2, 1'b0);
      run_check(4);
      check("pre_rst_lights", 32'(lights), 32'(lt(2, Y)));
      rst = 1'b1;
      #1;
      check("async_lights", 32'(lights),      32'(lt(0, G)));
      check("async_dir",    32'(cur_dir),     32'd0);
      check("async_ps",     32'(phase_start), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      car = '0;
      push(5, lt(0, G), 2'd0, 1'b0);
      run_check(5);

      scen = "end";
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
